// File: rtl/ex_if_pkg.sv
// Shared types and constants for the elevator controller: FSM states, travel direction,
// bit positions of the hardware control/feedback bytes and the default door dwell.
package ex_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR_OPEN = 2'd3
  } state_e;

  // Up encodes as 0 so the status byte reads all-zero straight out of reset.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int MOTOR_UP_BIT   = 0;
  localparam int MOTOR_DOWN_BIT = 1;
  localparam int DOOR_OPEN_BIT  = 2;
  localparam int AT_FLOOR_BIT   = 7;

  localparam int DOOR_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/ex_if_elevator_ctrl_if.sv
// Bundle of software request, hardware control/feedback and status signals of the elevator controller.
interface ex_if_elevator_ctrl_if #(
  parameter int FLOOR_W    = 2,
  parameter int NUM_FLOORS = 4
);

  logic                  sw_req_valid;
  logic [FLOOR_W-1:0]    sw_req_floor;
  logic                  sw_req_ready;
  logic [7:0]            data_from_exHW;
  logic [7:0]            data_to_exHW;
  logic [7:0]            data_to_SW;
  logic [NUM_FLOORS-1:0] pending;

  modport master (
    output sw_req_valid, sw_req_floor, data_from_exHW,
    input  sw_req_ready, data_to_exHW, data_to_SW, pending
  );

  modport slave (
    input  sw_req_valid, sw_req_floor, data_from_exHW,
    output sw_req_ready, data_to_exHW, data_to_SW, pending
  );

endinterface

// File: rtl/ex_if_door_timer.sv
// Door dwell counter: start_i (re)loads the dwell, done_o flags the last open cycle has elapsed.
module ex_if_door_timer
  import ex_if_pkg::*;
#(
  parameter int DOOR_CYCLES = DOOR_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic done_o
);

  localparam logic [7:0] LOAD = 8'(DOOR_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  // NOTE: cnt_d gets its default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = LOAD;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == 8'd0);

endmodule

// File: rtl/ex_if_elevator_ctrl.sv
// Elevator controller top: request intake, car FSM and registered motor/door/status outputs.
// Build option EX_IF_STATUS_EN: data_to_SW carries FSM status instead of echoing data_from_exHW.
module ex_if_elevator_ctrl
  import ex_if_pkg::*;
#(
  parameter int FLOOR_W     = 2,
  parameter int NUM_FLOORS  = 4,
  parameter int DOOR_CYCLES = DOOR_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  ex_if_elevator_ctrl_if.slave bus
);

  localparam int                 SPAN      = 1 << FLOOR_W;
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

  state_e                state_q, state_d;
  dir_e                  dir_q, dir_d;
  logic                  err_q, err_d;
  logic [FLOOR_W-1:0]    cur_floor_q, cur_floor_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [7:0]            exhw_q, exhw_d;
  logic [7:0]            status_q, status_d;

  logic [FLOOR_W-1:0] hw_floor, floor_now;
  logic               at_floor, accept, req_in_range, req_here, set_req;
  logic [SPAN-1:0]    pend_span;
  logic               pend_here, pend_above, pend_below;
  logic               timer_start, timer_done, clear_here;

  assign hw_floor = bus.data_from_exHW[FLOOR_W-1:0];
  assign at_floor = bus.data_from_exHW[AT_FLOOR_BIT];
  // Between floors every decision uses the last floor the car was aligned with.
  assign floor_now = at_floor ? hw_floor : cur_floor_q;

  assign bus.sw_req_ready = ~reset;
  assign accept           = bus.sw_req_valid & bus.sw_req_ready;
  assign req_in_range     = 32'(bus.sw_req_floor) < NUM_FLOORS;
  assign req_here         = req_in_range & (bus.sw_req_floor == floor_now);
  // A call for the floor the door is already open at only extends the dwell.
  assign set_req          = accept & req_in_range & ~((state_q == ST_DOOR_OPEN) & req_here);

  assign pend_span = SPAN'(pending_q);
  assign pend_here = pend_span[floor_now];

  always_comb begin
    pend_above = 1'b0;
    pend_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(floor_now)) pend_above = pend_above | pending_q[i];
      if (i < int'(floor_now)) pend_below = pend_below | pending_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_start = 1'b0;
    clear_here  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (at_floor && pend_here) begin
          state_d     = ST_DOOR_OPEN;
          timer_start = 1'b1;
          clear_here  = 1'b1;
        end else if (pend_above && pend_below) begin
          state_d = (dir_q == DIR_UP) ? ST_MOVE_UP : ST_MOVE_DOWN;
        end else if (pend_above) begin
          state_d = ST_MOVE_UP;
        end else if (pend_below) begin
          state_d = ST_MOVE_DOWN;
        end
      end
      ST_MOVE_UP: begin
        if (at_floor && pend_here) begin
          state_d     = ST_DOOR_OPEN;
          timer_start = 1'b1;
          clear_here  = 1'b1;
        end else if ((floor_now == TOP_FLOOR) || (at_floor && !pend_above)) begin
          state_d = ST_IDLE;
        end
      end
      ST_MOVE_DOWN: begin
        if (at_floor && pend_here) begin
          state_d     = ST_DOOR_OPEN;
          timer_start = 1'b1;
          clear_here  = 1'b1;
        end else if ((floor_now == '0) || (at_floor && !pend_below)) begin
          state_d = ST_IDLE;
        end
      end
      ST_DOOR_OPEN: begin
        if (accept && req_here) begin
          timer_start = 1'b1;
        end else if (timer_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dir_d = dir_q;
    if (state_d == ST_MOVE_UP) begin
      dir_d = DIR_UP;
    end else if (state_d == ST_MOVE_DOWN) begin
      dir_d = DIR_DOWN;
    end

    err_d       = err_q | (accept & ~req_in_range);
    cur_floor_d = floor_now;

    // Clear is applied after set so a same-cycle request for the served floor is absorbed.
    pending_d = pending_q;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (set_req && (int'(bus.sw_req_floor) == i)) pending_d[i] = 1'b1;
      if (clear_here && (int'(floor_now) == i))     pending_d[i] = 1'b0;
    end

    exhw_d                 = 8'h00;
    exhw_d[MOTOR_UP_BIT]   = (state_d == ST_MOVE_UP);
    exhw_d[MOTOR_DOWN_BIT] = (state_d == ST_MOVE_DOWN);
    exhw_d[DOOR_OPEN_BIT]  = (state_d == ST_DOOR_OPEN);

`ifdef EX_IF_STATUS_EN
    status_d = {state_d, dir_d, err_d, 4'(cur_floor_d)};
`else
    status_d = bus.data_from_exHW;
`endif
  end

`ifdef EX_IF_STATUS_EN
  logic unused_hw_bits;
  assign unused_hw_bits = ^bus.data_from_exHW;
`endif

  ex_if_door_timer #(
    .DOOR_CYCLES(DOOR_CYCLES)
  ) u_door_timer (
    .clk    (clk),
    .rst    (reset),
    .start_i(timer_start),
    .done_o (timer_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_UP;
      err_q       <= 1'b0;
      cur_floor_q <= '0;
      pending_q   <= '0;
      exhw_q      <= 8'h00;
      status_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
      cur_floor_q <= cur_floor_d;
      pending_q   <= pending_d;
      exhw_q      <= exhw_d;
      status_q    <= status_d;
    end
  end

  assign bus.data_to_exHW = exhw_q;
  assign bus.data_to_SW   = status_q;
  assign bus.pending      = pending_q;

endmodule

// File: tb/tb_ex_if_elevator_ctrl.sv
// Directed bench for ex_if_elevator_ctrl: a 4-floor car with a 3-bit floor field and 16-cycle dwell.
module tb_ex_if_elevator_ctrl;

  localparam int FLOOR_W     = 3;
  localparam int NUM_FLOORS  = 4;
  localparam int DOOR_CYCLES = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;
  localparam logic [1:0] S_DOOR = 2'd3;

  localparam logic [7:0] HW_STOP = 8'h00;
  localparam logic [7:0] HW_UP   = 8'h01;
  localparam logic [7:0] HW_DOWN = 8'h02;
  localparam logic [7:0] HW_DOOR = 8'h04;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] last_hw;
  int         n_checks = 0;
  int         n_errors = 0;
  int         door_len;

  ex_if_elevator_ctrl_if #(.FLOOR_W(FLOOR_W), .NUM_FLOORS(NUM_FLOORS)) bus ();

  ex_if_elevator_ctrl #(
    .FLOOR_W    (FLOOR_W),
    .NUM_FLOORS (NUM_FLOORS),
    .DOOR_CYCLES(DOOR_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Advance one edge; remember the feedback byte the DUT sampled there.
  task automatic tick();
    logic [7:0] snap;
    snap = bus.data_from_exHW;
    @(posedge clk);
    last_hw = snap;
    #1;
  endtask

  function automatic logic [7:0] hw(input logic at, input logic [2:0] fl);
    return {at, 4'b0000, fl};
  endfunction

  task automatic req(input logic [2:0] fl);
    bus.sw_req_valid = 1'b1;
    bus.sw_req_floor = fl;
    tick();
    bus.sw_req_valid = 1'b0;
  endtask

  task automatic check_sw(input string tag, input logic [1:0] st, input logic dr,
                          input logic er, input logic [3:0] fl);
`ifdef EX_IF_STATUS_EN
    check(tag, bus.data_to_SW, {st, dr, er, fl});
`else
    check(tag, bus.data_to_SW, last_hw);
`endif
  endtask

  // Called on the first cycle the door shows open; counts open cycles, bounded.
  task automatic measure_door(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.data_to_exHW[2]) n++;
      else break;
      tick();
    end
  endtask

  initial begin
    reset              = 1'b1;
    bus.sw_req_valid   = 1'b0;
    bus.sw_req_floor   = '0;
    bus.data_from_exHW = hw(1'b1, 3'd0);
    last_hw            = 8'h00;

    repeat (3) tick();
    check("rst_exhw", bus.data_to_exHW, 8'h00);
    check("rst_sw", bus.data_to_SW, 8'h00);
    check("rst_ready", 8'(bus.sw_req_ready), 8'h00);
    check("rst_pending", 8'(bus.pending), 8'h00);
    reset = 1'b0;
    #1;
    check("ready_high", 8'(bus.sw_req_ready), 8'h01);
    tick();
    check("idle_exhw", bus.data_to_exHW, HW_STOP);
    check_sw("idle_sw", S_IDLE, 1'b0, 1'b0, 4'd0);

    // Car idle at 0, call to 2: motor up one edge after the accept, door for 16 cycles at 2.
    req(3'd2);
    check("t1_pending", 8'(bus.pending), 8'h04);
    tick();
    check("t1_motor_up", bus.data_to_exHW, HW_UP);
    check_sw("t1_sw_up", S_UP, 1'b0, 1'b0, 4'd0);
    bus.data_from_exHW = hw(1'b0, 3'd0); tick();
    bus.data_from_exHW = hw(1'b1, 3'd1); tick();
    check("t1_pass_1", bus.data_to_exHW, HW_UP);
    bus.data_from_exHW = hw(1'b0, 3'd1); tick();
    bus.data_from_exHW = hw(1'b1, 3'd2); tick();
    check("t1_door", bus.data_to_exHW, HW_DOOR);
    check("t1_pend_clr", 8'(bus.pending), 8'h00);
    check_sw("t1_sw_door", S_DOOR, 1'b0, 1'b0, 4'd2);
    measure_door(door_len);
    check("t1_door_len", 8'(door_len), 8'd16);
    check("t1_idle", bus.data_to_exHW, HW_STOP);
    check_sw("t1_sw_idle", S_IDLE, 1'b0, 1'b0, 4'd2);

    // Re-call floor 2 on the 10th open cycle: dwell restarts for 16 more cycles, no pending bit.
    req(3'd2);
    check("t4_pend_set", 8'(bus.pending), 8'h04);
    tick();
    check("t4_door", bus.data_to_exHW, HW_DOOR);
    check("t4_pend_clr", 8'(bus.pending), 8'h00);
    repeat (9) tick();
    req(3'd2);
    check("t4_no_pend", 8'(bus.pending), 8'h00);
    measure_door(door_len);
    check("t4_restart_len", 8'(door_len), 8'd16);

    // Go down to 1, then from 1 call 3 and 0 while heading up: 3 served first, then down.
    req(3'd1);
    check("t2_pend_1", 8'(bus.pending), 8'h02);
    tick();
    check("t2_down_to_1", bus.data_to_exHW, HW_DOWN);
    check_sw("t2_sw_down", S_DOWN, 1'b1, 1'b0, 4'd2);
    bus.data_from_exHW = hw(1'b0, 3'd2); tick();
    bus.data_from_exHW = hw(1'b1, 3'd1); tick();
    check("t2_door_1", bus.data_to_exHW, HW_DOOR);
    measure_door(door_len);
    check("t2_door1_len", 8'(door_len), 8'd16);
    req(3'd3);
    req(3'd0);
    check("t2_up", bus.data_to_exHW, HW_UP);
    check("t2_pend_both", 8'(bus.pending), 8'h09);
    check_sw("t2_sw_up", S_UP, 1'b0, 1'b0, 4'd1);
    bus.data_from_exHW = hw(1'b0, 3'd1); tick();
    bus.data_from_exHW = hw(1'b1, 3'd2); tick();
    check("t2_pass_2", bus.data_to_exHW, HW_UP);
    bus.data_from_exHW = hw(1'b0, 3'd2); tick();
    bus.data_from_exHW = hw(1'b1, 3'd3); tick();
    check("t2_door_3", bus.data_to_exHW, HW_DOOR);
    check("t2_pend_0", 8'(bus.pending), 8'h01);
    measure_door(door_len);
    check("t2_door3_len", 8'(door_len), 8'd16);
    tick();
    check("t2_down_to_0", bus.data_to_exHW, HW_DOWN);
    check_sw("t2_sw_down0", S_DOWN, 1'b1, 1'b0, 4'd3);

    // Out-of-range call: dropped, sticky error.
    req(3'd5);
    check("t3_pend_same", 8'(bus.pending), 8'h01);
    check("t3_still_down", bus.data_to_exHW, HW_DOWN);
    check_sw("t3_sw_err", S_DOWN, 1'b1, 1'b1, 4'd3);
    repeat (2) tick();
    check_sw("t3_sw_err_hold", S_DOWN, 1'b1, 1'b1, 4'd3);

    // Asynchronous reset while motor_down is on.
    bus.data_from_exHW = hw(1'b0, 3'd3); tick();
    check("t5_moving", bus.data_to_exHW, HW_DOWN);
    #2 reset = 1'b1;
    #1;
    check("t5_exhw_async", bus.data_to_exHW, 8'h00);
    check("t5_pending_async", 8'(bus.pending), 8'h00);
    check("t5_sw_async", bus.data_to_SW, 8'h00);
    check("t5_ready_async", 8'(bus.sw_req_ready), 8'h00);
    tick();
    reset              = 1'b0;
    bus.data_from_exHW = hw(1'b1, 3'd0);
    repeat (2) tick();
    check("t5_idle_exhw", bus.data_to_exHW, HW_STOP);
    check("t5_idle_pending", 8'(bus.pending), 8'h00);
    check_sw("t5_sw_cleared", S_IDLE, 1'b0, 1'b0, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
